// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver.
// Matches a 7-bit address with W direction, ACKs it and every following
// data byte, and presents each received byte with a one-cycle valid pulse.
// SCL/SDA are expected to be already synchronous to clk_i; START/STOP
// detection happens upstream and arrives as single-cycle pulses.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk_i,
  input  logic       rstn,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_q;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        sda_oe_q, sda_oe_d;
  logic        addr_match_q, addr_match_d;
  // Set after the first SCL fall of an ACK slot; the second fall ends it.
  logic        ack_q, ack_d;
  // The completed data byte is published one cycle after its 8th rise.
  logic        load_q, load_d;

  logic        rise;
  logic        fall;

  assign rise = scl & ~scl_q;
  assign fall = ~scl & scl_q;

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      scl_q        <= 1'b1;
      shift_q      <= 8'h00;
      cnt_q        <= 3'd0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      sda_oe_q     <= 1'b0;
      addr_match_q <= 1'b0;
      ack_q        <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_q        <= scl;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      sda_oe_q     <= sda_oe_d;
      addr_match_q <= addr_match_d;
      ack_q        <= ack_d;
      load_q       <= load_d;
    end
  end

  // Next-state logic; START beats STOP, and bus conditions mask SCL edges.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    sda_oe_d     = sda_oe_q;
    addr_match_d = addr_match_q;
    ack_d        = ack_q;
    load_d       = 1'b0;

    // A byte that completed last cycle is always published, even if a bus
    // condition arrives now: it was whole when its 8th bit was sampled.
    if (load_q) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end

    if (start_det) begin
      state_d      = S_ADDR;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      cnt_d        = 3'd0;
      ack_d        = 1'b0;
    end else if (stop_det) begin
      state_d      = S_IDLE;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      cnt_d        = 3'd0;
      ack_d        = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (rise) begin
            shift_d = {shift_q[6:0], sda_i};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // Address bits are the seven already shifted; sda_i is R/W.
              if ((shift_q[6:0] == SLAVE_ADDR) && !sda_i) begin
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (fall) begin
            if (!ack_q) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
              ack_d        = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_d    = 1'b0;
              cnt_d    = 3'd0;
              state_d  = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rise) begin
            shift_d = {shift_q[6:0], sda_i};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              load_d  = 1'b1;
              state_d = S_DATA_ACK;
            end
          end
        end
        S_DATA_ACK: begin
          if (fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_d    = 1'b0;
              cnt_d    = 3'd0;
              state_d  = S_DATA;
            end
          end
        end
        S_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: drives SCL/SDA bit by bit and checks ACK
// timing, received bytes, address rejection, repeated START and reset.
module tb_i2c_slave_rx;

  logic       clk_i;
  logic       rstn;
  logic       start_det;
  logic       stop_det;
  logic       scl;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       busy;

  int tests_run;
  int tests_failed;
  int valid_cnt;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
    .clk_i     (clk_i),
    .rstn      (rstn),
    .start_det (start_det),
    .stop_det  (stop_det),
    .scl       (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .addr_match(addr_match),
    .busy      (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count rx_valid pulses, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (rstn && rx_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic do_start();
    scl       = 1'b1;
    sda_line  = 1'b0;
    start_det = 1'b1;
    @(negedge clk_i);
    start_det = 1'b0;
    scl       = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic do_stop();
    scl      = 1'b1;
    stop_det = 1'b1;
    @(negedge clk_i);
    stop_det = 1'b0;
    sda_line = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic send_bit(input logic b);
    sda_line = b;
    repeat (2) @(negedge clk_i);
    scl = 1'b1;
    repeat (4) @(negedge clk_i);
    scl = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  // Eight bits MSB first, then the ninth clock with SDA released by the
  // master; reports sda_oe mid low phase, end of high phase, and after.
  task automatic send_byte(input logic [7:0] b, output logic ack_low,
                           output logic ack_end, output logic ack_after);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_line = 1'b1;
    repeat (2) @(negedge clk_i);
    ack_low = sda_oe;
    scl = 1'b1;
    repeat (4) @(negedge clk_i);
    ack_end = sda_oe;
    scl = 1'b0;
    repeat (2) @(negedge clk_i);
    ack_after = sda_oe;
  endtask

  task automatic test_reset();
    rstn = 1'b0; scl = 1'b1; sda_line = 1'b1; start_det = 1'b0; stop_det = 1'b0;
    valid_cnt = 0;
    repeat (3) @(negedge clk_i);
    rstn = 1'b1;
    @(negedge clk_i);
    $display("[TB] reset released");
    tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    tests_run++; if (addr_match !== 1'b0) begin tests_failed++; $display("FAIL reset_addr_match got %b want 0", addr_match); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int v0;
    do_start();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_after_start got %b want 1", busy); end
    send_byte(8'hA0, a0, a1, a2);
    $display("[TB] write: addr A0 ack_low=%b ack_end=%b after=%b addr_match=%b", a0, a1, a2, addr_match);
    tests_run++; if (a0 !== 1'b1) begin tests_failed++; $display("FAIL wr_addr_ack_low got %b want 1", a0); end
    tests_run++; if (a1 !== 1'b1) begin tests_failed++; $display("FAIL wr_addr_ack_end got %b want 1", a1); end
    tests_run++; if (a2 !== 1'b0) begin tests_failed++; $display("FAIL wr_addr_ack_release got %b want 0", a2); end
    tests_run++; if (addr_match !== 1'b1) begin tests_failed++; $display("FAIL wr_addr_match got %b want 1", addr_match); end
    v0 = valid_cnt;
    send_byte(8'h3C, a0, a1, a2);
    $display("[TB] write: data 3C rx_data=%h valid_pulses=%0d ack_low=%b", rx_data, valid_cnt - v0, a0);
    tests_run++; if (valid_cnt - v0 !== 1) begin tests_failed++; $display("FAIL wr_valid_count got %0d want 1", valid_cnt - v0); end
    tests_run++; if (rx_data !== 8'h3C) begin tests_failed++; $display("FAIL wr_rx_data got %h want 3c", rx_data); end
    tests_run++; if (a0 !== 1'b1 || a1 !== 1'b1 || a2 !== 1'b0) begin tests_failed++; $display("FAIL wr_data_ack got %b%b%b want 110", a0, a1, a2); end
    do_stop();
    $display("[TB] write: stop busy=%b addr_match=%b rx_data=%h", busy, addr_match, rx_data);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_stop_busy got %b want 0", busy); end
    tests_run++; if (addr_match !== 1'b0) begin tests_failed++; $display("FAIL wr_stop_addr_match got %b want 0", addr_match); end
    tests_run++; if (rx_data !== 8'h3C) begin tests_failed++; $display("FAIL wr_stop_rx_data got %h want 3c", rx_data); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2;
    int v0;
    v0 = valid_cnt;
    do_start();
    send_byte(8'hA2, a0, a1, a2);
    $display("[TB] wrong addr A2: ack_low=%b ack_end=%b addr_match=%b busy=%b", a0, a1, addr_match, busy);
    tests_run++; if (a0 !== 1'b0 || a1 !== 1'b0) begin tests_failed++; $display("FAIL wa_nack got %b%b want 00", a0, a1); end
    tests_run++; if (addr_match !== 1'b0) begin tests_failed++; $display("FAIL wa_addr_match got %b want 0", addr_match); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wa_busy_ignore got %b want 1", busy); end
    send_byte(8'h55, a0, a1, a2);
    send_byte(8'hFF, a0, a1, a2);
    $display("[TB] wrong addr: two bytes ignored valid_pulses=%0d", valid_cnt - v0);
    tests_run++; if (valid_cnt - v0 !== 0) begin tests_failed++; $display("FAIL wa_no_valid got %0d want 0", valid_cnt - v0); end
    tests_run++; if (a0 !== 1'b0) begin tests_failed++; $display("FAIL wa_data_nack got %b want 0", a0); end
    do_stop();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wa_stop_busy got %b want 0", busy); end
  endtask

  task automatic test_read_addr();
    logic a0, a1, a2;
    do_start();
    send_byte(8'hA1, a0, a1, a2);
    $display("[TB] read addr A1: ack_low=%b addr_match=%b busy=%b", a0, addr_match, busy);
    tests_run++; if (a0 !== 1'b0 || a1 !== 1'b0) begin tests_failed++; $display("FAIL rd_nack got %b%b want 00", a0, a1); end
    tests_run++; if (addr_match !== 1'b0) begin tests_failed++; $display("FAIL rd_addr_match got %b want 0", addr_match); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy_ignore got %b want 1", busy); end
    do_stop();
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    int v0;
    do_start();
    send_byte(8'hA0, a0, a1, a2);
    v0 = valid_cnt;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    do_start();
    tests_run++; if (addr_match !== 1'b0) begin tests_failed++; $display("FAIL rs_addr_match_cleared got %b want 0", addr_match); end
    send_byte(8'hA0, a0, a1, a2);
    $display("[TB] repeated start: partial valid_pulses=%0d new ack_low=%b", valid_cnt - v0, a0);
    tests_run++; if (valid_cnt - v0 !== 0) begin tests_failed++; $display("FAIL rs_no_partial_valid got %0d want 0", valid_cnt - v0); end
    tests_run++; if (a0 !== 1'b1) begin tests_failed++; $display("FAIL rs_new_addr_ack got %b want 1", a0); end
    send_byte(8'h81, a0, a1, a2);
    $display("[TB] repeated start: data 81 rx_data=%h valid_pulses=%0d", rx_data, valid_cnt - v0);
    tests_run++; if (rx_data !== 8'h81) begin tests_failed++; $display("FAIL rs_rx_data got %h want 81", rx_data); end
    tests_run++; if (valid_cnt - v0 !== 1) begin tests_failed++; $display("FAIL rs_valid_count got %0d want 1", valid_cnt - v0); end
    do_stop();
  endtask

  task automatic test_reset_mid_ack();
    logic a0, a1, a2;
    int v0;
    do_start();
    for (int i = 7; i >= 0; i--) send_bit(8'hA0 >> i);
    sda_line = 1'b1;
    repeat (2) @(negedge clk_i);
    tests_run++; if (sda_oe !== 1'b1) begin tests_failed++; $display("FAIL rm_ack_before_reset got %b want 1", sda_oe); end
    #2 rstn = 1'b0;
    #1;
    $display("[TB] reset mid-ack: sda_oe=%b busy=%b addr_match=%b rx_data=%h", sda_oe, busy, addr_match, rx_data);
    tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL rm_async_sda_oe got %b want 0", sda_oe); end
    tests_run++; if (busy !== 1'b0 || addr_match !== 1'b0) begin tests_failed++; $display("FAIL rm_busy_match got %b%b want 00", busy, addr_match); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL rm_rx_data got %h want 00", rx_data); end
    scl = 1'b1;
    repeat (2) @(negedge clk_i);
    rstn = 1'b1;
    repeat (2) @(negedge clk_i);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_idle_after_release got %b want 0", busy); end
    v0 = valid_cnt;
    do_start();
    send_byte(8'hA0, a0, a1, a2);
    send_byte(8'hC5, a0, a1, a2);
    $display("[TB] reset mid-ack: recovery data C5 rx_data=%h valid_pulses=%0d", rx_data, valid_cnt - v0);
    tests_run++; if (rx_data !== 8'hC5 || valid_cnt - v0 !== 1) begin tests_failed++; $display("FAIL rm_recovery got %h/%0d want c5/1", rx_data, valid_cnt - v0); end
    do_stop();
  endtask

  task automatic test_start_stop_same();
    scl       = 1'b1;
    start_det = 1'b1;
    stop_det  = 1'b1;
    @(negedge clk_i);
    start_det = 1'b0;
    stop_det  = 1'b0;
    @(negedge clk_i);
    $display("[TB] start+stop same cycle: busy=%b", busy);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ss_start_wins got %b want 1", busy); end
    do_stop();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_write();
    test_wrong_addr();
    test_read_addr();
    test_repeated_start();
    test_reset_mid_ack();
    test_start_stop_same();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter: SLAVE_ADDR, 7'h50, 7-bit address this slave answers to.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start_det  input  1  one-cycle pulse from the start/stop detector; START or repeated START seen.
REQ-005 stop_det  input  1  one-cycle pulse from the start/stop detector; STOP seen.
REQ-006 scl  input  1  I2C clock level, synchronous to clk_i.
REQ-007 sda_i  input  1  I2C data level, synchronous to clk_i.
REQ-008 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release SDA.
REQ-009 rx_data  output  8  last received data byte, MSB first on the wire.
REQ-010 rx_valid  output  1  one-cycle pulse; rx_data holds a new byte.
REQ-011 addr_match  output  1  high from address ACK until STOP or next START.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Edge detect: scl_d = scl registered; rise = scl & ~scl_d; fall = ~scl & scl_d.
REQ-014 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE: ignore scl edges; start_det -> ADDR.
REQ-016 ADDR: on each rise, shift sda_i into an 8-bit shift register (LSB in) and increment the 3-bit bit counter.
REQ-017 ADDR, 8th rise: if shift[7:1]==SLAVE_ADDR and bit0 (R/W)==0 -> ADDR_ACK; otherwise -> IGNORE with sda_oe kept at 0.
REQ-018 ADDR_ACK: first fall -> sda_oe=1 and addr_match=1; next fall -> sda_oe=0, counter cleared, -> DATA.
REQ-019 DATA: shift on each rise as in ADDR; on 8th rise, the following cycle loads rx_data with the byte and pulses rx_valid for 1 cycle; -> DATA_ACK.
REQ-020 DATA_ACK: first fall -> sda_oe=1; next fall -> sda_oe=0, counter cleared, -> DATA (unlimited bytes).
REQ-021 IGNORE: ignore scl edges; sda_oe=0; leave only via start_det or stop_det.
REQ-022 sda_oe is registered: it changes in the clk_i cycle after the cycle in which fall is detected.
REQ-023 stop_det in any state -> IDLE, sda_oe=0, addr_match=0, counter cleared; rx_data retained.
REQ-024 start_det in any state (repeated START) -> ADDR, sda_oe=0, addr_match=0, counter cleared.
REQ-025 start_det and stop_det in the same cycle: start_det wins.
REQ-026 scl edge coinciding with start_det or stop_det: the edge is ignored.
REQ-027 Bit counter wraps 7->0 only via the explicit clear in ACK states; no partial-byte rx_valid when a START or STOP cuts a byte short.
REQ-028 SLAVE_ADDR 7'h00 (general call) receives no special treatment; it matches only on equality.

Reset
REQ-029 rstn=0 forces immediately: state=IDLE, scl_d=1, shift=0, counter=0, rx_data=8'h00, rx_valid=0, sda_oe=0, addr_match=0, busy=0.
REQ-030 Reset asserted mid-byte or mid-ACK releases SDA at once; after release, the block waits in IDLE for start_det.

Verification
REQ-031 START, address 0xA0 (7'h50, W), 8 SCL pulses -> sda_oe=1 from the 9th SCL low phase through its end; addr_match=1.
REQ-032 Then data 0x3C -> rx_valid pulses once; rx_data=8'h3C; ACK driven; STOP -> busy=0, addr_match=0, rx_data still 8'h3C.
REQ-033 START, address 0xA2 (7'h51) -> sda_oe never asserts; state IGNORE; following bytes give no rx_valid until STOP.
REQ-034 START, address 0xA1 (7'h50, R) -> NACK (sda_oe stays 0); IGNORE.
REQ-035 After a matched write, 4 data bits then repeated START, address 0xA0 -> no rx_valid for the partial byte; new address ACKed.
REQ-036 rstn pulsed low while sda_oe=1 during ACK -> sda_oe=0 asynchronously; all outputs at reset values; next full transaction succeeds.
